eth_crc_stream: RTL and testbench

ETH_CRC_STREAM -- requirements
Module: eth_crc_stream

---
 rtl/eth_crc_stream.sv | 153 +++++++++++++++
 tb/tb_eth_crc_stream.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_crc_stream.sv
// Streaming Ethernet CRC-32 over byte-enabled beats.
// Reports the final CRC, residue check, byte count and keep errors per frame.
module eth_crc_stream #(
    parameter int          DATA_WIDTH    = 32,
    parameter logic [31:0] CRC_POLY      = 32'h04C11DB7,
    parameter logic [31:0] CRC_INIT      = 32'hFFFFFFFF,
    parameter logic [31:0] CRC_XOROUT    = 32'hFFFFFFFF,
    parameter logic [31:0] CHECK_RESIDUE = 32'hDEBB20E3
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    in_v_i,
    output logic                    in_ready_o,
    input  logic [DATA_WIDTH-1:0]   in_data_i,
    input  logic [DATA_WIDTH/8-1:0] in_keep_i,
    input  logic                    in_last_i,
    output logic                    crc_v_o,
    input  logic                    crc_yumi_i,
    output logic [31:0]             crc_o,
    output logic                    crc_ok_o,
    output logic [15:0]             len_o,
    output logic                    err_o
);

    localparam int KW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic logic [31:0] reflect32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[31-i];
        end
        return r;
    endfunction

    // LSB-first update uses the bit-reversed polynomial.
    localparam logic [31:0] POLY_R = reflect32(CRC_POLY);

    // Fold every enabled byte, lowest index first, into the running state.
    function automatic logic [31:0] crc_bytes(
        input logic [31:0]           seed,
        input logic [DATA_WIDTH-1:0] data,
        input logic [KW-1:0]         keep
    );
        logic [31:0] c;
        logic        fb;
        c = seed;
        for (int b = 0; b < KW; b++) begin
            if (keep[b]) begin
                for (int i = 0; i < 8; i++) begin
                    fb = c[0] ^ data[8*b+i];
                    c  = {1'b0, c[31:1]} ^ (fb ? POLY_R : 32'h0);
                end
            end
        end
        return c;
    endfunction

    function automatic logic [3:0] popcount(input logic [KW-1:0] keep);
        logic [3:0] n;
        n = 4'd0;
        for (int b = 0; b < KW; b++) begin
            n = n + 4'(keep[b]);
        end
        return n;
    endfunction

    state_t       state_q, state_d;
    logic [31:0]  crc_q, crc_d;
    logic [15:0]  len_q, len_d;
    logic         err_q, err_d;

    logic         accept;
    logic [31:0]  seed;
    logic [15:0]  len_base;
    logic         err_base;
    logic [16:0]  len_sum;
    logic         beat_err;
    logic [KW-1:0] keep_inc;

    assign in_ready_o = (state_q != DONE);
    assign accept     = in_v_i && in_ready_o;

    // A frame's first beat restarts from the init value and clear counters.
    assign seed     = (state_q == IDLE) ? CRC_INIT : crc_q;
    assign len_base = (state_q == IDLE) ? 16'h0 : len_q;
    assign err_base = (state_q == IDLE) ? 1'b0 : err_q;

    assign len_sum  = {1'b0, len_base} + {13'd0, popcount(in_keep_i)};
    assign keep_inc = in_keep_i + KW'(1);

    // Keep must be full mid-frame; last beat must be a non-empty low run.
    always_comb begin
        beat_err = 1'b0;
        if (in_last_i) begin
            beat_err = (in_keep_i == '0) ||
                       ((in_keep_i & keep_inc) != '0);
        end else begin
            beat_err = (in_keep_i != '1);
        end
    end

    // Next-state and accumulator update.
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        len_d   = len_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE, BUSY: begin
                if (accept) begin
                    crc_d   = crc_bytes(seed, in_data_i, in_keep_i);
                    len_d   = len_sum[16] ? 16'hFFFF : len_sum[15:0];
                    err_d   = err_base | beat_err;
                    state_d = in_last_i ? DONE : BUSY;
                end
            end
            DONE: begin
                if (crc_yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and accumulator registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            crc_q   <= CRC_INIT;
            len_q   <= 16'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    assign crc_v_o  = (state_q == DONE);
    assign crc_o    = crc_q ^ CRC_XOROUT;
    assign crc_ok_o = crc_v_o && (crc_q == CHECK_RESIDUE);
    assign len_o    = len_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_eth_crc_stream.sv
// Directed bench for eth_crc_stream at 8, 32 and 64-bit beat widths.
// Expected values are the well-known CRC-32 check string results.
module tb_eth_crc_stream;

    logic clk;
    logic rst_n;

    logic        v32, r32, l32, y32, cv32, ok32, e32;
    logic [31:0] d32, c32;
    logic [3:0]  k32;
    logic [15:0] n32;

    logic        v8, r8, l8, y8, cv8, ok8, e8;
    logic [7:0]  d8;
    logic [31:0] c8;
    logic [0:0]  k8;
    logic [15:0] n8;

    logic        v64, r64, l64, y64, cv64, ok64, e64;
    logic [63:0] d64;
    logic [31:0] c64;
    logic [7:0]  k64;
    logic [15:0] n64;

    int n_run;
    int n_fail;

    eth_crc_stream #(.DATA_WIDTH(32)) u32 (
        .clk_i(clk), .reset_n_i(rst_n),
        .in_v_i(v32), .in_ready_o(r32), .in_data_i(d32),
        .in_keep_i(k32), .in_last_i(l32),
        .crc_v_o(cv32), .crc_yumi_i(y32), .crc_o(c32),
        .crc_ok_o(ok32), .len_o(n32), .err_o(e32)
    );

    eth_crc_stream #(.DATA_WIDTH(8)) u8 (
        .clk_i(clk), .reset_n_i(rst_n),
        .in_v_i(v8), .in_ready_o(r8), .in_data_i(d8),
        .in_keep_i(k8), .in_last_i(l8),
        .crc_v_o(cv8), .crc_yumi_i(y8), .crc_o(c8),
        .crc_ok_o(ok8), .len_o(n8), .err_o(e8)
    );

    eth_crc_stream #(.DATA_WIDTH(64)) u64 (
        .clk_i(clk), .reset_n_i(rst_n),
        .in_v_i(v64), .in_ready_o(r64), .in_data_i(d64),
        .in_keep_i(k64), .in_last_i(l64),
        .crc_v_o(cv64), .crc_yumi_i(y64), .crc_o(c64),
        .crc_ok_o(ok64), .len_o(n64), .err_o(e64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic beat32(input logic [31:0] d,
                          input logic [3:0] k,
                          input logic l);
        @(negedge clk);
        v32 = 1'b1; d32 = d; k32 = k; l32 = l;
    endtask

    task automatic end32();
        @(negedge clk);
        v32 = 1'b0; l32 = 1'b0;
    endtask

    task automatic yumi32();
        y32 = 1'b1;
        @(negedge clk);
        y32 = 1'b0;
    endtask

    task automatic str32();
        beat32(32'h34333231, 4'hF, 1'b0);
        beat32(32'h38373635, 4'hF, 1'b0);
        beat32(32'h00000039, 4'h1, 1'b1);
        end32();
    endtask

    task automatic fcs32(input logic [7:0] b0, input logic [7:0] blast);
        beat32({24'h343332, b0}, 4'hF, 1'b0);
        beat32(32'h38373635, 4'hF, 1'b0);
        beat32(32'hF4392639, 4'hF, 1'b0);
        beat32({24'h0, blast}, 4'h1, 1'b1);
        end32();
    endtask

    task automatic beat64(input logic [63:0] d,
                          input logic [7:0] k,
                          input logic l);
        @(negedge clk);
        v64 = 1'b1; d64 = d; k64 = k; l64 = l;
    endtask

    initial begin
        n_run = 0; n_fail = 0;
        rst_n = 1'b0;
        v32 = 0; d32 = '0; k32 = '0; l32 = 0; y32 = 0;
        v8  = 0; d8  = '0; k8  = '0; l8  = 0; y8  = 0;
        v64 = 0; d64 = '0; k64 = '0; l64 = 0; y64 = 0;

        repeat (2) @(negedge clk);
        check("rst_crc",   c32, 32'h0);
        check("rst_v",     {31'h0, cv32}, 32'h0);
        check("rst_rdy",   {31'h0, r32}, 32'h1);
        check("rst_len",   {16'h0, n32}, 32'h0);
        check("rst_ok",    {31'h0, ok32}, 32'h0);
        check("rst_err",   {31'h0, e32}, 32'h0);
        rst_n = 1'b1;

        // Check string, three beats, partial last beat.
        str32();
        check("s32_v",   {31'h0, cv32}, 32'h1);
        check("s32_crc", c32, 32'hCBF43926);
        check("s32_len", {16'h0, n32}, 32'd9);
        check("s32_err", {31'h0, e32}, 32'h0);
        check("s32_ok",  {31'h0, ok32}, 32'h0);

        // Hold the result with input pending; nothing may be consumed.
        v32 = 1'b1; d32 = 32'h34333231; k32 = 4'hF; l32 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_rdy", {31'h0, r32}, 32'h0);
            check("hold_v",   {31'h0, cv32}, 32'h1);
            check("hold_crc", c32, 32'hCBF43926);
            check("hold_len", {16'h0, n32}, 32'd9);
        end
        yumi32();
        check("yumi_v",   {31'h0, cv32}, 32'h0);
        check("yumi_rdy", {31'h0, r32}, 32'h1);
        beat32(32'h38373635, 4'hF, 1'b0);
        beat32(32'h00000039, 4'h1, 1'b1);
        end32();
        check("next_crc", c32, 32'hCBF43926);
        check("next_len", {16'h0, n32}, 32'd9);
        yumi32();

        // Frame with FCS appended, then corrupted variants.
        fcs32(8'h31, 8'hCB);
        check("fcs_ok",  {31'h0, ok32}, 32'h1);
        check("fcs_len", {16'h0, n32}, 32'd13);
        check("fcs_err", {31'h0, e32}, 32'h0);
        yumi32();
        fcs32(8'h30, 8'hCB);
        check("flipd_ok", {31'h0, ok32}, 32'h0);
        yumi32();
        fcs32(8'h31, 8'hCA);
        check("flipf_ok", {31'h0, ok32}, 32'h0);
        yumi32();

        // Keep protocol violations.
        beat32(32'h34333231, 4'h7, 1'b0);
        beat32(32'h38373635, 4'hF, 1'b0);
        beat32(32'h00000039, 4'h1, 1'b1);
        end32();
        check("kmid_err", {31'h0, e32}, 32'h1);
        check("kmid_len", {16'h0, n32}, 32'd8);
        yumi32();
        beat32(32'h34333231, 4'h5, 1'b1);
        end32();
        check("klast_err", {31'h0, e32}, 32'h1);
        check("klast_len", {16'h0, n32}, 32'd2);
        yumi32();
        str32();
        check("eclr_err", {31'h0, e32}, 32'h0);
        yumi32();

        // Asynchronous reset in the middle of a frame.
        beat32(32'h34333231, 4'hF, 1'b0);
        beat32(32'h38373635, 4'hF, 1'b0);
        end32();
        #2 rst_n = 1'b0;
        #1;
        check("mrst_crc", c32, 32'h0);
        check("mrst_len", {16'h0, n32}, 32'h0);
        check("mrst_v",   {31'h0, cv32}, 32'h0);
        check("mrst_rdy", {31'h0, r32}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        str32();
        check("mrst_next", c32, 32'hCBF43926);
        check("mrst_nlen", {16'h0, n32}, 32'd9);
        yumi32();

        // 8-bit beats.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            v8 = 1'b1; d8 = 8'h31 + 8'(i); k8 = 1'b1; l8 = (i == 8);
        end
        @(negedge clk);
        v8 = 1'b0; l8 = 1'b0;
        check("w8_v",   {31'h0, cv8}, 32'h1);
        check("w8_crc", c8, 32'hCBF43926);
        check("w8_len", {16'h0, n8}, 32'd9);
        y8 = 1'b1;
        @(negedge clk);
        y8 = 1'b0;

        // 64-bit beats.
        beat64(64'h3837363534333231, 8'hFF, 1'b0);
        beat64(64'h0000000000000039, 8'h01, 1'b1);
        @(negedge clk);
        v64 = 1'b0; l64 = 1'b0;
        check("w64_v",   {31'h0, cv64}, 32'h1);
        check("w64_crc", c64, 32'hCBF43926);
        check("w64_len", {16'h0, n64}, 32'd9);
        y64 = 1'b1;
        @(negedge clk);
        y64 = 1'b0;

        // Length saturation: 8200 full beats is 65600 bytes.
        for (int i = 0; i < 8200; i++) begin
            beat64(64'h0123456789ABCDEF, 8'hFF, 1'b0);
        end
        beat64(64'h0, 8'h01, 1'b1);
        @(negedge clk);
        v64 = 1'b0; l64 = 1'b0;
        check("sat_len", {16'h0, n64}, 32'h0000FFFF);
        check("sat_err", {31'h0, e64}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
